fetch_issue_queue: RTL

//  Parametrised instruction queue between IF and ID, replacing the fixed two-slot IF/ID handoff.
//  IF pushes up to FETCH_W instructions per cycle from IM; ID pops up to ISSUE_W per cycle.
//  The queue absorbs FREEZE stalls and mismatched fetch/issue widths, and empties on a taken-branch flush.

---
 rtl/fetch_issue_queue.sv | 110 +++++++++++
 1 files changed

// File: rtl/fetch_issue_queue.sv
// rtl/fetch_issue_queue.sv - IF->ID instruction queue with contiguous multi-slot push/pop
// Optional same-cycle fetch-to-issue bypass when FIQ_BYPASS_EN is defined.
module fetch_issue_queue #(
  parameter int DEPTH   = 8,
  parameter int FETCH_W = 2,
  parameter int ISSUE_W = 2
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         flush,
  input  logic [FETCH_W-1:0]           fetch_valid,
  input  logic [FETCH_W*32-1:0]        fetch_instr,
  input  logic [31:0]                  fetch_pc,
  output logic                         fetch_ready,
  output logic [ISSUE_W-1:0]           issue_valid,
  output logic [ISSUE_W*32-1:0]        issue_instr,
  output logic [ISSUE_W*32-1:0]        issue_pc,
  input  logic [$clog2(ISSUE_W+1)-1:0] issue_take,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         err_take
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   mem_instr [DEPTH];
  logic [31:0]   mem_pc    [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;

  int   n_lead;
  int   n_acc;
  int   avail;
  int   n_pop;
  logic take_err;

  // Leading contiguous valid run: index of the first clear bit, or FETCH_W.
  always_comb begin
    n_lead = FETCH_W;
    for (int k = FETCH_W - 1; k >= 0; k--) begin
      if (!fetch_valid[k]) n_lead = k;
    end
  end

  // Conservative: a same-cycle pop never frees room for the incoming group.
  assign fetch_ready = (DEPTH - int'(count)) >= FETCH_W;

  always_comb begin
    n_acc = 0;
    if (fetch_ready && !flush) n_acc = n_lead;
  end

  always_comb begin
    issue_valid = '0;
    issue_instr = '0;
    issue_pc    = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      if (k < int'(count)) begin
        issue_valid[k]        = 1'b1;
        issue_instr[32*k +: 32] = mem_instr[head + AW'(k)];
        issue_pc[32*k +: 32]    = mem_pc[head + AW'(k)];
`ifdef FIQ_BYPASS_EN
      end else if ((k - int'(count)) < n_acc) begin
        issue_valid[k]        = 1'b1;
        issue_instr[32*k +: 32] = fetch_instr[32*(k - int'(count)) +: 32];
        issue_pc[32*k +: 32]    = fetch_pc + 32'(4 * (k - int'(count)));
`endif
      end
    end
  end

  always_comb begin
`ifdef FIQ_BYPASS_EN
    avail = int'(count) + n_acc;
`else
    avail = int'(count);
`endif
    take_err = int'(issue_take) > avail;
    n_pop    = take_err ? avail : int'(issue_take);
  end

  // Incoming slots are always written at tail; bypassed ones are skipped by head advancing past them.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      err_take <= 1'b0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(n_pop);
      tail  <= tail + AW'(n_acc);
      count <= CW'(int'(count) + n_acc - n_pop);
      if (take_err) err_take <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    for (int k = 0; k < FETCH_W; k++) begin
      if (k < n_acc) begin
        mem_instr[tail + AW'(k)] <= fetch_instr[32*k +: 32];
        mem_pc[tail + AW'(k)]    <= fetch_pc + 32'(4 * k);
      end
    end
  end

endmodule
